// File: rtl/spu_sr_pkg.sv
// Shared types and helpers for the SPU even-pipe shift/rotate unit.
package spu_sr_pkg;

    localparam int unsigned HW = 16;
    localparam int unsigned W  = 32;

    typedef enum logic [3:0] {
        NOP    = 4'd0,
        SHLH   = 4'd1,
        SHL    = 4'd2,
        ROTH   = 4'd3,
        ROT    = 4'd4,
        ROTHM  = 4'd5,
        ROTM   = 4'd6,
        ROTMAH = 4'd7,
        ROTMA  = 4'd8
    } sr_op_t;

    // Element width in bits for a legal op; 0 marks NOP and undefined encodings.
    function automatic logic [5:0] elem_bits(input sr_op_t op);
        case (op)
            SHLH, ROTH, ROTHM, ROTMAH: elem_bits = 6'(HW);
            SHL, ROT, ROTM, ROTMA:     elem_bits = 6'(W);
            default:                   elem_bits = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/spu_sr_lane.sv
// One 32-bit lane: either two independent halfword elements or one word element.
module spu_sr_lane
    import spu_sr_pkg::*;
(
    input  logic [31:0] ra,
    input  logic [31:0] cnt,
    input  logic [6:0]  imm7,
    input  sr_op_t      op,
    input  logic        src_imm,
    output logic [31:0] result_c
);

    function automatic logic [15:0] half_op(input sr_op_t f, input logic [15:0] a, input logic [4:0] n);
        logic [4:0]  neg;
        logic [15:0] r;
        neg = 5'd0 - n;
        case (f)
            SHLH:    r = n[4] ? 16'd0 : a << n[3:0];
            ROTH:    r = (a << n[3:0]) | (a >> (5'd16 - {1'b0, n[3:0]}));
            ROTHM:   r = neg[4] ? 16'd0 : a >> neg[3:0];
            ROTMAH:  r = 16'($signed(a) >>> (neg[4] ? 4'd15 : neg[3:0]));
            default: r = 16'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] word_op(input sr_op_t f, input logic [31:0] a, input logic [5:0] n);
        logic [5:0]  neg;
        logic [31:0] r;
        neg = 6'd0 - n;
        case (f)
            SHL:     r = n[5] ? 32'd0 : a << n[4:0];
            ROT:     r = (a << n[4:0]) | (a >> (6'd32 - {1'b0, n[4:0]}));
            ROTM:    r = neg[5] ? 32'd0 : a >> neg[4:0];
            ROTMA:   r = 32'($signed(a) >>> (neg[5] ? 5'd31 : neg[4:0]));
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    logic [15:0] cnt_h0;
    logic [15:0] cnt_h1;
    logic [31:0] cnt_w;
    logic        unused_cnt;

    // Immediate counts are sign-extended to the element width, identical for every element.
    assign cnt_h0 = src_imm ? {{9{imm7[6]}}, imm7}  : cnt[31:16];
    assign cnt_h1 = src_imm ? {{9{imm7[6]}}, imm7}  : cnt[15:0];
    assign cnt_w  = src_imm ? {{25{imm7[6]}}, imm7} : cnt;

    // Only the low count bits matter once negation wraps at element width.
    assign unused_cnt = ^{cnt_h0[15:5], cnt_h1[15:5], cnt_w[31:6]};

    always_comb begin
        result_c = '0;
        if (elem_bits(op) == 6'(HW)) begin
            result_c = {half_op(op, ra[31:16], cnt_h0[4:0]), half_op(op, ra[15:0], cnt_h1[4:0])};
        end else if (elem_bits(op) == 6'(W)) begin
            result_c = word_op(op, ra, cnt_w[5:0]);
        end
    end

endmodule

// File: rtl/spu_shift_rotate_pipe.sv
// Even-pipe shift/rotate unit: stage-1 compute, delay pipeline with flush and forwarding taps.
module spu_shift_rotate_pipe
    import spu_sr_pkg::*;
#(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned ADDR_W  = 7
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           issue_valid,
    input  sr_op_t                         op,
    input  logic                           src_imm,
    input  logic [ADDR_W-1:0]              rt_addr,
    input  logic [DATA_W-1:0]              ra,
    input  logic [DATA_W-1:0]              rb,
    input  logic [6:0]                     imm7,
    input  logic                           reg_write,
    input  logic                           flush,
    output logic                           wb_valid,
    output logic [DATA_W-1:0]              rt_wb,
    output logic [ADDR_W-1:0]              rt_addr_wb,
    output logic                           reg_write_wb,
    output logic [LATENCY-2:0]             tap_valid,
    output logic [(LATENCY-1)*ADDR_W-1:0]  tap_addr,
    output logic [(LATENCY-1)*DATA_W-1:0]  tap_data
);

    localparam int unsigned LANES = DATA_W / 32;
    localparam int unsigned NTAP  = LATENCY - 1;

    logic [DATA_W-1:0] result_c;
    logic              capture_c;

    logic [LATENCY-1:0] stage_valid;
    logic [DATA_W-1:0]  stage_data [LATENCY];
    logic [ADDR_W-1:0]  stage_addr [LATENCY];
    logic [LATENCY-1:0] stage_we;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        spu_sr_lane u_lane (
            .ra       (ra[g*32 +: 32]),
            .cnt      (rb[g*32 +: 32]),
            .imm7     (imm7),
            .op       (op),
            .src_imm  (src_imm),
            .result_c (result_c[g*32 +: 32])
        );
    end

    assign capture_c = issue_valid && !flush && (elem_bits(op) != 6'd0);

    // Invalid stages hold all-zero fields, so shifting needs no extra masking.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            stage_valid <= '0;
            stage_we    <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stage_data[i] <= '0;
                stage_addr[i] <= '0;
            end
        end else begin
            stage_valid   <= {stage_valid[LATENCY-2:0], capture_c};
            stage_we      <= {stage_we[LATENCY-2:0], capture_c & reg_write};
            stage_data[0] <= capture_c ? result_c : '0;
            stage_addr[0] <= capture_c ? rt_addr : '0;
            for (int i = 1; i < LATENCY; i++) begin
                stage_data[i] <= stage_data[i-1];
                stage_addr[i] <= stage_addr[i-1];
            end
        end
    end

    assign wb_valid     = stage_valid[LATENCY-1];
    assign rt_wb        = stage_data[LATENCY-1];
    assign rt_addr_wb   = stage_addr[LATENCY-1];
    assign reg_write_wb = stage_we[LATENCY-1];

    // Stage 1 lands in the most-significant tap slice.
    for (genvar s = 1; s < LATENCY; s++) begin : g_tap
        assign tap_valid[NTAP-s]                   = stage_valid[s-1];
        assign tap_addr[(NTAP-s)*ADDR_W +: ADDR_W] = stage_addr[s-1];
        assign tap_data[(NTAP-s)*DATA_W +: DATA_W] = stage_data[s-1];
    end

endmodule

// File: tb/tb_spu_shift_rotate_pipe.sv
// Scoreboard bench for spu_shift_rotate_pipe: directed vectors, decoupled writeback monitor.
module tb_spu_shift_rotate_pipe;
    import spu_sr_pkg::*;

    localparam int unsigned DATA_W  = 128;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned NTAP    = LATENCY - 1;
    localparam int unsigned CW      = NTAP * DATA_W;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     issue_valid;
    sr_op_t                   op;
    logic                     src_imm;
    logic [ADDR_W-1:0]        rt_addr;
    logic [DATA_W-1:0]        ra;
    logic [DATA_W-1:0]        rb;
    logic [6:0]               imm7;
    logic                     reg_write;
    logic                     flush;
    logic                     wb_valid;
    logic [DATA_W-1:0]        rt_wb;
    logic [ADDR_W-1:0]        rt_addr_wb;
    logic                     reg_write_wb;
    logic [NTAP-1:0]          tap_valid;
    logic [NTAP*ADDR_W-1:0]   tap_addr;
    logic [CW-1:0]            tap_data;

    spu_shift_rotate_pipe #(.DATA_W(DATA_W), .LATENCY(LATENCY), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .op           (op),
        .src_imm      (src_imm),
        .rt_addr      (rt_addr),
        .ra           (ra),
        .rb           (rb),
        .imm7         (imm7),
        .reg_write    (reg_write),
        .flush        (flush),
        .wb_valid     (wb_valid),
        .rt_wb        (rt_wb),
        .rt_addr_wb   (rt_addr_wb),
        .reg_write_wb (reg_write_wb),
        .tap_valid    (tap_valid),
        .tap_addr     (tap_addr),
        .tap_data     (tap_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              we;
        int                due;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wb_valid"},  CW'(wb_valid), '0);
        check({tag, "_rt_wb"},     CW'(rt_wb), '0);
        check({tag, "_addr_we"},   CW'({rt_addr_wb, reg_write_wb}), '0);
        check({tag, "_tap_valid"}, CW'(tap_valid), '0);
        check({tag, "_tap_addr"},  CW'(tap_addr), '0);
        check({tag, "_tap_data"},  tap_data, '0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        op          = NOP;
        src_imm     = 1'b0;
        rt_addr     = '0;
        ra          = '0;
        rb          = '0;
        imm7        = '0;
        reg_write   = 1'b0;
    endtask

    // Drives one issue for the coming edge; expected writeback is due LATENCY-1 edges after it.
    task automatic drive(input sr_op_t o, input logic si, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] ra_v, input logic [DATA_W-1:0] rb_v,
                         input logic [6:0] im, input logic we, input logic exp_wb,
                         input logic [DATA_W-1:0] exp_data);
        exp_t e;
        issue_valid = 1'b1;
        op          = o;
        src_imm     = si;
        rt_addr     = a;
        ra          = ra_v;
        rb          = rb_v;
        imm7        = im;
        reg_write   = we;
        if (exp_wb) begin
            e.data = exp_data;
            e.addr = a;
            e.we   = we;
            e.due  = cyc + int'(LATENCY);
            sb.push_back(e);
        end
    endtask

    // Writeback monitor.
    always @(negedge clk) begin
        exp_t e;
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wb: rt_wb=%h addr=%0d, required no writeback", rt_wb, rt_addr_wb);
            end else begin
                e = sb.pop_front();
                check("wb_data",    CW'(rt_wb), CW'(e.data));
                check("wb_addr",    CW'(rt_addr_wb), CW'(e.addr));
                check("wb_we",      CW'(reg_write_wb), CW'(e.we));
                check("wb_latency", CW'(cyc), CW'(e.due));
            end
        end else if (reset === 1'b0) begin
            check("idle_rt_wb", CW'(rt_wb), '0);
            check("idle_we",    CW'(reg_write_wb), '0);
        end
    end

    initial begin
        logic [DATA_W-1:0] tap1;
        logic [ADDR_W-1:0] tap1_addr;

        reset = 1'b1;
        flush = 1'b0;
        idle();
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b0;

        // SHLH single issue, with stage-1 tap check
        tick();
        drive(SHLH, 1'b0, 7'd5, {8{16'h8001}},
              {16'd1, 16'd16, 16'h21, 16'd0, 16'd15, 16'd17, 16'h1F, 16'd2}, 7'd0, 1'b1, 1'b1,
              {16'h0002, 16'h0000, 16'h0002, 16'h8001, 16'h8000, 16'h0000, 16'h0000, 16'h0004});
        tick();
        idle();
        tap1      = tap_data[CW-1 -: DATA_W];
        tap1_addr = tap_addr[NTAP*ADDR_W-1 -: ADDR_W];
        check("tap1_valid", CW'(tap_valid), CW'(3'b100));
        check("tap1_data",  CW'(tap1), CW'({16'h0002, 16'h0000, 16'h0002, 16'h8001,
                                            16'h8000, 16'h0000, 16'h0000, 16'h0004}));
        check("tap1_addr",  CW'(tap1_addr), CW'(7'd5));
        repeat (LATENCY + 1) tick();

        // Back-to-back mix of ops
        tick();
        drive(ROT, 1'b0, 7'd10, {4{32'h80000001}}, {32'h21, 32'd0, 32'd31, 32'd4}, 7'd0, 1'b1, 1'b1,
              {32'h00000003, 32'h80000001, 32'hC0000000, 32'h00000018});
        tick();
        drive(ROT, 1'b1, 7'd11, {4{32'h80000001}}, {4{32'h00000001}}, 7'h7F, 1'b0, 1'b1,
              {4{32'hC0000000}});
        tick();
        drive(ROTMA, 1'b0, 7'd12, {32'h80000000, 32'h80000000, 32'h40000000, 32'h7FFFFFFF},
              {32'hFFFFFFFC, 32'hFFFFFFD8, 32'hFFFFFFFF, 32'h0}, 7'd0, 1'b1, 1'b1,
              {32'hF8000000, 32'hFFFFFFFF, 32'h20000000, 32'h7FFFFFFF});
        tick();
        drive(ROTMAH, 1'b1, 7'd13, {4{16'h8000, 16'h4000}}, '1, 7'h6C, 1'b1, 1'b1,
              {4{16'hFFFF, 16'h0000}});
        tick();
        drive(ROTM, 1'b0, 7'd14, {4{32'hFFFFFFFF}},
              {32'hFFFFFFE0, 32'hFFFFFFFF, 32'hFFFFFFE1, 32'h0}, 7'd0, 1'b1, 1'b1,
              {32'h0, 32'h7FFFFFFF, 32'h00000001, 32'hFFFFFFFF});
        tick();
        drive(ROTHM, 1'b0, 7'd15, {8{16'hFFFF}}, {2{16'hFFFD, 16'hFFF0, 16'hFFF1, 16'h0000}},
              7'd0, 1'b1, 1'b1, {2{16'h1FFF, 16'h0000, 16'h0001, 16'hFFFF}});
        tick();
        drive(ROTH, 1'b0, 7'd16, {8{16'h8001}}, {2{16'd1, 16'h10, 16'd15, 16'd4}},
              7'd0, 1'b1, 1'b1, {2{16'h0003, 16'h8001, 16'hC000, 16'h0018}});
        tick();
        drive(SHL, 1'b0, 7'd17, {4{32'h00000001}}, {32'd31, 32'd32, 32'h41, 32'd0},
              7'd0, 1'b1, 1'b1, {32'h80000000, 32'h0, 32'h00000002, 32'h00000001});
        tick();
        idle();
        repeat (LATENCY + 1) tick();

        // Three in flight, then flush together with a fourth issue
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(SHL, 1'b0, 7'(20 + i), {4{32'h00000001}}, {4{32'd1}}, 7'd0, 1'b1, 1'b0, '0);
        end
        tick();
        check("pre_flush_taps", CW'(tap_valid), CW'(3'b111));
        drive(ROT, 1'b0, 7'd23, {4{32'h1}}, {4{32'd2}}, 7'd0, 1'b1, 1'b0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        check_all_zero("flush");
        drive(ROT, 1'b0, 7'd24, {4{32'h12345678}}, {4{32'd8}}, 7'd0, 1'b1, 1'b1,
              {4{32'h34567812}});
        tick();
        idle();
        repeat (LATENCY + 1) tick();

        // Reset with three ops in flight, then NOP / undefined encodings
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(ROTH, 1'b0, 7'(30 + i), {8{16'h00FF}}, {8{16'd4}}, 7'd0, 1'b1, 1'b0, '0);
        end
        tick();
        reset = 1'b1;
        idle();
        tick();
        check_all_zero("reset_mid");
        reset = 1'b0;
        drive(NOP, 1'b0, 7'd40, '1, '1, 7'd0, 1'b1, 1'b0, '0);
        tick();
        drive(sr_op_t'(4'd12), 1'b0, 7'd41, '1, '1, 7'd0, 1'b1, 1'b0, '0);
        tick();
        drive(sr_op_t'(4'd15), 1'b1, 7'd42, '1, '1, 7'h7F, 1'b1, 1'b0, '0);
        tick();
        idle();
        for (int i = 0; i < int'(LATENCY); i++) begin
            tick();
            check("illegal_wb_valid", CW'(wb_valid), '0);
            check("illegal_we",       CW'(reg_write_wb), '0);
        end
        drive(SHLH, 1'b1, 7'd50, {8{16'h0101}}, '0, 7'd4, 1'b1, 1'b1, {8{16'h1010}});
        tick();
        idle();

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("drain_empty", CW'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
